key_scanner: RTL and testbench
==============================

KEY_SCANNER -- requirements
Module: key_scanner

Interface
REQ-001 SHALL have parameter SETTLE_W, default 4: width of the row-settle counter; settle time is 2^SETTLE_W cycles.
REQ-002 SHALL have parameter STABLE_W, default 2: width of the debounce counter; a stable level needs 2^STABLE_W consecutive equal samples.
REQ-003 SHALL have parameter REPEAT_W, default 8: width of the auto-repeat counter (used only under REQ-024).
REQ-004 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port row_n, output, 4: keypad row drive, active-low, at most one bit low.
REQ-007 SHALL have port col_n, input, 4: keypad column sense, active-low (0 = pressed), asynchronous to clk.
REQ-008 SHALL have port key_code, output, 4: key index = row*4 + col.
REQ-009 SHALL have port key_valid, output, 1: key_code holds an unconsumed key.
REQ-010 SHALL have port key_ready, input, 1: the consumer accepts the key when key_valid and key_ready are both high.
REQ-011 SHALL have port overrun, output, 1: sticky flag set when an unconsumed key is overwritten.

Function
REQ-012 SHALL pass col_n through a 2-flop synchronizer before any use; "sample" below means the synchronized value.
REQ-013 SHALL implement FSM states SCAN, SETTLE, DEBOUNCE, EMIT and RELEASE, and hold a 2-bit row index.
REQ-014 SCAN SHALL drive row_n low on the current row only, clear the settle counter and go to SETTLE next cycle.
REQ-015 SETTLE SHALL count 2^SETTLE_W cycles, then evaluate the sample as follows.
- All high: increment the row index (3 wraps to 0) and go to SCAN.
- Otherwise: latch the lowest-index low column and go to DEBOUNCE.
REQ-016 DEBOUNCE SHALL reset its counter whenever the sample differs from the previous sample. It SHALL return to SCAN on the same row if the latched column samples high. It SHALL go to EMIT when the counter reaches all-ones with the latched column low.
REQ-017 EMIT SHALL, in one cycle, write {row, col} into key_code, set key_valid and go to RELEASE.
REQ-018 RELEASE SHALL keep driving the row. It SHALL go to SCAN with the next row after 2^STABLE_W consecutive all-high samples; any low sample restarts that count.
REQ-019 key_valid SHALL clear on the cycle after key_valid && key_ready. key_code SHALL hold its value while key_valid is high and no new write occurs.
REQ-020 A write while key_valid is high and key_ready is low SHALL replace key_code and set overrun. A write coinciding with acceptance SHALL keep key_valid high with the new code and leave overrun unchanged.
REQ-021 Simultaneous presses on one row SHALL report only the lowest column. Other rows SHALL not be seen until the current key is released.
REQ-022 overrun SHALL clear only on reset.

Reset
REQ-023 On rst high, the block SHALL asynchronously set the following, and SHALL start in SCAN with row 0 on the first edge after rst falls:
- row_n = 4'b1111, key_code = 0, key_valid = 0, overrun = 0;
- synchronizer flops = 4'b1111;
- all counters = 0, row index = 0, state = SCAN.
A reset mid-key SHALL discard that key without emitting it.

Configuration
REQ-024 With KEY_SCANNER_REPEAT_EN defined, RELEASE SHALL count cycles while the key stays pressed. At all-ones of the REPEAT_W counter it SHALL re-emit the same code per REQ-017/REQ-020 and restart the count.
REQ-025 Without KEY_SCANNER_REPEAT_EN, no repeat counter SHALL exist, and each press SHALL emit exactly once.

Structure
REQ-026 key_scanner_pkg SHALL hold the FSM state type, the row count constant (4), the column count constant (4) and the key_code width constant (4).
REQ-027 The synchronizer SHALL be the sub-module col_sync (2 flops, 4 bits wide, reset value all-ones).

Verification
REQ-028 Bench: the defaults apply throughout, and key_ready is held high unless stated.
- No key pressed for 200 cycles -> row_n cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110; key_valid stays 0.
- Row 2 / col 1 held stable -> key_code = 9 and key_valid = 1 for exactly one cycle; no second emit until release.
- Col bounces 0/1 every cycle for 10 cycles, then stays low -> exactly one emit, no earlier than 4 stable cycles after the last bounce.
- key_ready = 0; press key 3 and release, then press key 12 -> key_code = 12, key_valid = 1, overrun = 1.
- rst pulsed during DEBOUNCE -> row_n = 1111 and key_valid = 0 immediately; with the key still held, a single emit follows after a full rescan.
- KEY_SCANNER_REPEAT_EN defined, key 5 held for 600 cycles -> first emit, then a re-emit of 5 every 256 cycles; no emits after release.

Source files
------------

// File: rtl/key_scanner_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_scanner_pkg : shared types/constants for the 4x4 key scanner    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package key_scanner_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int CODE_W   = 4;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_SCAN     = 3'd0;
   localparam logic [2:0] ST_SETTLE   = 3'd1;
   localparam logic [2:0] ST_DEBOUNCE = 3'd2;
   localparam logic [2:0] ST_EMIT     = 3'd3;
   localparam logic [2:0] ST_RELEASE  = 3'd4;

   // Index of the lowest active-low column; only called when one is low.
   function automatic logic [1:0] lowest_low(input logic [3:0] s);
      if (!s[0])      return 2'd0;
      else if (!s[1]) return 2'd1;
      else if (!s[2]) return 2'd2;
      else            return 2'd3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_scanner_col_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | col_sync : 2-flop synchronizer for the column sense lines           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module col_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d_i,
   output logic [3:0] q_o
);

   logic [3:0] meta_q;
   logic [3:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/key_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | key_scanner : 4x4 keypad scanner with debounce and key handshake    |
// | Optional auto-repeat: define KEY_SCANNER_REPEAT_EN.  Rev 1.0        |
// +--------------------------------------------------------------------+
module key_scanner
   import key_scanner_pkg::*;
#(
   parameter int SETTLE_W = 4,
   parameter int STABLE_W = 2,
   parameter int REPEAT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [3:0]        row_n,
   input  logic [3:0]        col_n,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              overrun
);

   if (SETTLE_W < 1 || STABLE_W < 1 || REPEAT_W < 1) begin : g_param_check
      $error("key_scanner: counter widths must be at least 1");
   end

   logic [3:0]          sample;
   logic [3:0]          prev_q;
   state_t              state_q, state_d;
   logic [1:0]          row_q, row_d;
   logic [1:0]          col_q, col_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [STABLE_W-1:0] stable_q, stable_d;
   logic [3:0]          row_n_q;
   logic [CODE_W-1:0]   key_code_q;
   logic                key_valid_q;
   logic                overrun_q;
   logic                do_emit;
`ifdef KEY_SCANNER_REPEAT_EN
   logic [REPEAT_W-1:0] rep_q, rep_d;
`endif

   col_sync u_col_sync (
      .clk (clk),
      .rst (rst),
      .d_i (col_n),
      .q_o (sample)
   );

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      settle_d = settle_q;
      stable_d = stable_q;
      do_emit  = 1'b0;
`ifdef KEY_SCANNER_REPEAT_EN
      rep_d    = rep_q;
`endif
      case (state_q)
         ST_SCAN: begin
            settle_d = '0;
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == '1) begin
               if (sample == 4'hF) begin
                  row_d   = row_q + 2'd1;
                  state_d = ST_SCAN;
               end else begin
                  col_d    = lowest_low(sample);
                  stable_d = '0;
                  state_d  = ST_DEBOUNCE;
               end
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (sample[col_q])          state_d  = ST_SCAN;
            else if (sample != prev_q)  stable_d = '0;
            else if (stable_q == '1)    state_d  = ST_EMIT;
            else                        stable_d = stable_q + 1'b1;
         end
         ST_EMIT: begin
            do_emit  = 1'b1;
            stable_d = '0;
            state_d  = ST_RELEASE;
`ifdef KEY_SCANNER_REPEAT_EN
            rep_d    = '0;
`endif
         end
         ST_RELEASE: begin
            if (sample != 4'hF) begin
               stable_d = '0;
            end else if (stable_q == '1) begin
               row_d   = row_q + 2'd1;
               state_d = ST_SCAN;
            end else begin
               stable_d = stable_q + 1'b1;
            end
`ifdef KEY_SCANNER_REPEAT_EN
            // Repeat timer runs only while the latched key is still down.
            if (!sample[col_q]) begin
               if (rep_q == '1) begin
                  do_emit = 1'b1;
                  rep_d   = '0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end else begin
               rep_d = '0;
            end
`endif
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         row_q       <= 2'd0;
         col_q       <= 2'd0;
         settle_q    <= '0;
         stable_q    <= '0;
         prev_q      <= 4'hF;
         row_n_q     <= 4'hF;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         settle_q <= settle_d;
         stable_q <= stable_d;
         prev_q   <= sample;
         row_n_q  <= ~(4'b0001 << row_d);
         if (do_emit) begin
            key_code_q  <= {row_q, col_q};
            key_valid_q <= 1'b1;
            if (key_valid_q && !key_ready) overrun_q <= 1'b1;
         end else if (key_valid_q && key_ready) begin
            key_valid_q <= 1'b0;
         end
      end
   end

`ifdef KEY_SCANNER_REPEAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rep_q <= '0;
      else     rep_q <= rep_d;
   end
`endif

   assign row_n     = row_n_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_key_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_key_scanner : directed bench with keypad model and scoreboard    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_key_scanner;
   import key_scanner_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready = 1'b1;
   logic        overrun;
   logic [15:0] keys = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int emits = 0;
   int last_emit = 0;
   int e0, last_bounce, n0;
   int exp_q[$];
   int emit_times[$];
   logic [3:0] prev_row;
   logic [3:0] seq[$];
   logic [3:0] exp_rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

   key_scanner dut (
      .clk       (clk),
      .rst       (rst),
      .row_n     (row_n),
      .col_n     (col_n),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Passive keypad: a pressed key shorts its driven row onto its column.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (key_valid === 1'b1 && key_ready === 1'b1) begin
         emits++;
         last_emit = cyc;
         emit_times.push_back(cyc);
         check("sb_expected_emit", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) check("sb_key_code", key_code, exp_q.pop_front());
      end
   end

   task automatic wait_for_state(input logic [2:0] st, input int max, input string tag);
      int n = 0;
      while (dut.state_q !== st && n < max) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_state_reached"}, dut.state_q, st);
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (key_valid !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, key_valid, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_row_n", row_n, 4'hF);
      check("reset_key_valid", key_valid, 0);
      check("reset_key_code", key_code, 0);
      check("reset_overrun", overrun, 0);
      rst = 1'b0;

      // Idle scan: rows must rotate 0,1,2,3,0 with no emits.
      prev_row = 4'hF;
      repeat (200) begin
         @(negedge clk);
         if (row_n !== prev_row) begin
            seq.push_back(row_n);
            prev_row = row_n;
         end
      end
      check("idle_transitions", (seq.size() >= 5), 1);
      if (seq.size() >= 5)
         for (int i = 0; i < 5; i++) check("idle_row_seq", seq[i], exp_rows[i]);
      check("idle_no_emit", emits, 0);

      // Stable press row 2 / col 1.
      e0 = emits;
      keys[9] = 1'b1;
      exp_q.push_back(9);
      repeat (200) @(negedge clk);
      check("key9_single_emit", emits - e0, 1);
      keys = '0;
      repeat (30) @(negedge clk);

      // Bouncing press on key 6 during debounce.
      e0 = emits;
      keys[6] = 1'b1;
      wait_for_state(ST_DEBOUNCE, 200, "bounce");
      exp_q.push_back(6);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         keys[6] = ~keys[6];
      end
      @(negedge clk);
      keys[6] = 1'b1;
      last_bounce = cyc;
      repeat (200) @(negedge clk);
      check("bounce_single_emit", emits - e0, 1);
      check("bounce_emit_after_stable", (last_emit - last_bounce >= 4), 1);
      keys = '0;
      repeat (30) @(negedge clk);

      // Overrun: key 3 left unconsumed, then key 12.
      e0 = emits;
      key_ready = 1'b0;
      keys[3] = 1'b1;
      wait_valid(300, "ovr_first");
      check("ovr_first_code", key_code, 3);
      check("ovr_first_no_overrun", overrun, 0);
      keys[3] = 1'b0;
      repeat (40) @(negedge clk);
      keys[12] = 1'b1;
      repeat (200) @(negedge clk);
      check("ovr_code", key_code, 12);
      check("ovr_valid", key_valid, 1);
      check("ovr_flag", overrun, 1);
      exp_q.push_back(12);
      key_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("ovr_accept_once", emits - e0, 1);
      keys = '0;
      repeat (40) @(negedge clk);
      check("ovr_sb_drained", exp_q.size(), 0);

      // Reset while debouncing key 9.
      keys[9] = 1'b1;
      wait_for_state(ST_DEBOUNCE, 200, "rst_db");
      e0 = emits;
      #2 rst = 1'b1;
      #1;
      check("rst_mid_row_n", row_n, 4'hF);
      check("rst_mid_valid", key_valid, 0);
      check("rst_mid_overrun", overrun, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(9);
      repeat (300) @(negedge clk);
      check("rst_single_emit", emits - e0, 1);
      check("rst_sb_drained", exp_q.size(), 0);
      keys = '0;
      repeat (40) @(negedge clk);

`ifdef KEY_SCANNER_REPEAT_EN
      // Auto-repeat on key 5.
      e0 = emits;
      n0 = emit_times.size();
      keys[5] = 1'b1;
      repeat (3) exp_q.push_back(5);
      for (int i = 0; i < 900 && (emits - e0) < 3; i++) @(negedge clk);
      check("rep_emit_count", emits - e0, 3);
      if (emit_times.size() >= n0 + 3) begin
         check("rep_interval_1", emit_times[n0+1] - emit_times[n0], 256);
         check("rep_interval_2", emit_times[n0+2] - emit_times[n0+1], 256);
      end
      keys = '0;
      repeat (300) @(negedge clk);
      check("rep_none_after_release", emits - e0, 3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
